vctr_fetch_sched: RTL and testbench

//  Pops vector addresses from the address FIFO, expands optional consecutive bursts and issues
//  32-bit read requests to the vector memory port. Read returns land in the vector FIFO.

---
 rtl/vctr_fetch_sched.sv | 149 ++++++++++++++
 tb/tb_vctr_fetch_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vctr_fetch_sched.sv
// vctr_fetch_sched: pops vector addresses, expands bursts and issues credit-throttled 32-bit reads.
// Define FETCH_STATS_EN to add the saturating total_vctr_fifo_words_written counter.
module vctr_fetch_sched #(
    parameter int ADDR_W          = 32,
    parameter int VCTR_FIFO_DEPTH = 8192,
    parameter int HEADROOM        = 16,
    parameter int MAX_OUTSTANDING = 32,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_program,
    input  logic              end_program,
    input  logic              abort_program,
    input  logic              freeze_addr_fifo,
    input  logic              freeze_vector_fifo,
    input  logic              send_consec_addr,
    input  logic [7:0]        consec_count,
    input  logic              vector_byte_swap,
    input  logic              addr_fifo_empty,
    input  logic [31:0]       addr_fifo_dout,
    output logic              addr_fifo_rd,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    input  logic [15:0]       words_in_vctr_fifo,
    output logic              vctr_fifo_wr,
    output logic [31:0]       vctr_fifo_din,
    output logic [OUT_W-1:0]  outstanding,
    output logic              seq_busy,
    output logic              seq_done
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       total_vctr_fifo_words_written
`endif
);
    typedef enum logic [2:0] {IDLE, POP, LATCH, ISSUE, DRAIN} state_t;

    localparam logic [16:0]    LIMIT = 17'(VCTR_FIFO_DEPTH - HEADROOM);
    localparam logic [OUT_W:0] MAX_O = (OUT_W + 1)'(MAX_OUTSTANDING);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic              req_q, req_d;
    logic              aborted_q, aborted_d;
    logic              wr_q;
    logic [31:0]       din_q;
    logic [OUT_W-1:0]  out_q;
    logic              stop, accept, ret, drop, room_now, room_nxt, unused_dout_lsb;
    logic [16:0]       fill;

    assign stop     = end_program || !active_program;
    assign accept   = req_q && mem_rd_ack;
    assign ret      = mem_rd_valid && out_q != '0;
    assign drop     = aborted_q || abort_program;
    assign fill     = {1'b0, words_in_vctr_fifo} + 17'(out_q) + 17'd1;
    // room_nxt assumes the request accepted this cycle already counts as in flight
    assign room_now = !freeze_vector_fifo && {1'b0, out_q} < MAX_O && fill <= LIMIT;
    assign room_nxt = !freeze_vector_fifo && {1'b0, out_q} + (OUT_W + 1)'(1) < MAX_O
                      && fill + 17'd1 <= LIMIT;
    assign unused_dout_lsb = ^addr_fifo_dout[1:0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        req_d        = 1'b0;
        aborted_d    = aborted_q;
        addr_fifo_rd = 1'b0;
        case (state_q)
            IDLE:  state_d = (active_program && !abort_program) ? POP : IDLE;
            POP: begin
                addr_fifo_rd = !stop && !addr_fifo_empty && !freeze_addr_fifo;
                state_d      = stop ? DRAIN : addr_fifo_rd ? LATCH : POP;
            end
            LATCH: begin
                addr_d  = {addr_fifo_dout[ADDR_W-1:2], 2'b00};
                rem_d   = send_consec_addr ? {1'b0, consec_count} + 9'd1 : 9'd1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    rem_d   = rem_q - 9'd1;
                    state_d = (rem_q != 9'd1) ? ISSUE : stop ? DRAIN : POP;
                    req_d   = (rem_q != 9'd1) && room_nxt;
                end else begin
                    req_d = req_q || room_now;
                end
            end
            DRAIN: begin
                state_d   = (out_q == '0) ? IDLE : DRAIN;
                aborted_d = (out_q != '0) && drop;
            end
            default: state_d = IDLE;
        endcase
        if (abort_program && state_q != IDLE && state_q != DRAIN) begin
            state_d      = DRAIN;
            aborted_d    = 1'b1;
            req_d        = 1'b0;
            addr_fifo_rd = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            req_q     <= 1'b0;
            aborted_q <= 1'b0;
            out_q     <= '0;
            wr_q      <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            req_q     <= req_d;
            aborted_q <= aborted_d;
            out_q     <= out_q + OUT_W'(accept) - OUT_W'(ret);
            wr_q      <= ret && !drop;
            din_q     <= vector_byte_swap ? {mem_rd_data[7:0], mem_rd_data[15:8],
                                             mem_rd_data[23:16], mem_rd_data[31:24]} : mem_rd_data;
        end
    end

    assign mem_rd_req    = req_q;
    assign mem_rd_addr   = addr_q;
    assign outstanding   = out_q;
    assign vctr_fifo_wr  = wr_q;
    assign vctr_fifo_din = din_q;
    assign seq_busy      = state_q != IDLE;
    assign seq_done      = state_q == DRAIN && out_q == '0 && !drop;

`ifdef FETCH_STATS_EN
    logic [31:0] stats_q;

    always_ff @(posedge clk) begin
        if (!reset || (state_q == IDLE && state_d == POP)) stats_q <= '0;
        else if (wr_q && stats_q != '1) stats_q <= stats_q + 32'd1;
    end

    assign total_vctr_fifo_words_written = stats_q;
`endif
endmodule

// File: tb/tb_vctr_fetch_sched.sv
// tb_vctr_fetch_sched: directed scenarios against behavioural address-FIFO and memory models.
module tb_vctr_fetch_sched;
    logic        clk = 1'b0;
    logic        reset, active_program, end_program, abort_program;
    logic        freeze_addr_fifo, freeze_vector_fifo, send_consec_addr, vector_byte_swap;
    logic [7:0]  consec_count;
    logic        addr_fifo_empty, addr_fifo_rd;
    logic [31:0] addr_fifo_dout;
    logic        mem_rd_req, mem_rd_ack, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic [15:0] words_in_vctr_fifo;
    logic        vctr_fifo_wr;
    logic [31:0] vctr_fifo_din;
    logic [5:0]  outstanding;
    logic        seq_busy, seq_done;
`ifdef FETCH_STATS_EN
    logic [31:0] total_vctr_fifo_words_written;
`endif

    logic        ack_en = 1'b1, ret_en = 1'b1, fixed_en = 1'b0, spur = 1'b0;
    logic [31:0] fixed_data = '0;
    logic [31:0] afifo[$], mq[$], reqlog[$], wlog[$];
    int          cyc = 0, wr_cyc = -1, val_cyc = -1, done_cnt = 0;
    int          n_cmp = 0, n_bad = 0;

    assign mem_rd_ack = ack_en;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vctr_fetch_sched dut (
        .clk(clk), .reset(reset), .active_program(active_program), .end_program(end_program),
        .abort_program(abort_program), .freeze_addr_fifo(freeze_addr_fifo),
        .freeze_vector_fifo(freeze_vector_fifo), .send_consec_addr(send_consec_addr),
        .consec_count(consec_count), .vector_byte_swap(vector_byte_swap),
        .addr_fifo_empty(addr_fifo_empty), .addr_fifo_dout(addr_fifo_dout),
        .addr_fifo_rd(addr_fifo_rd), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .words_in_vctr_fifo(words_in_vctr_fifo), .vctr_fifo_wr(vctr_fifo_wr),
        .vctr_fifo_din(vctr_fifo_din), .outstanding(outstanding), .seq_busy(seq_busy),
`ifdef FETCH_STATS_EN
        .total_vctr_fifo_words_written(total_vctr_fifo_words_written),
`endif
        .seq_done(seq_done)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // Address FIFO and memory: observe mid-low-phase, update just after the rising edge
    initial begin
        logic        do_pop, do_acc;
        logic [31:0] acc_addr;
        addr_fifo_empty = 1'b1;
        addr_fifo_dout  = '0;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        forever begin
            @(negedge clk); #2;
            do_pop   = addr_fifo_rd;
            do_acc   = mem_rd_req && mem_rd_ack;
            acc_addr = mem_rd_addr;
            if (vctr_fifo_wr) begin wlog.push_back(vctr_fifo_din); wr_cyc = cyc; end
            if (mem_rd_valid) val_cyc = cyc;
            if (seq_done) done_cnt++;
            if (do_acc) reqlog.push_back(acc_addr);
            @(posedge clk); #1;
            if (do_pop && afifo.size() > 0) addr_fifo_dout = afifo.pop_front();
            addr_fifo_empty = afifo.size() == 0;
            if (spur) begin
                mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF; spur = 1'b0;
            end else if (ret_en && mq.size() > 0) begin
                mem_rd_valid = 1'b1; mem_rd_data = mq.pop_front();
            end else begin
                mem_rd_valid = 1'b0;
            end
            if (do_acc) mq.push_back(fixed_en ? fixed_data : data_of(acc_addr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_prog(input int nreq, input string nm);
        int d0;
        d0 = done_cnt;
        active_program = 1'b1;
        for (int i = 0; i < 3000 && reqlog.size() < nreq; i++) @(negedge clk);
        for (int i = 0; i < 3000 && (outstanding != 0 || wlog.size() < nreq); i++) @(negedge clk);
        end_program = 1'b1;
        for (int i = 0; i < 100 && seq_done !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (seq_done !== 1'b1) begin n_bad++; $display("FAIL %s_done_timeout: got %b want 1", nm, seq_done); end
        active_program = 1'b0;
        end_program    = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL %s_done_pulses: got %0d want 1", nm, done_cnt - d0); end
        n_cmp++;
        if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle: busy got %b want 0", nm, seq_busy); end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({addr_fifo_rd, mem_rd_req, vctr_fifo_wr, seq_busy, seq_done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000",
                              {addr_fifo_rd, mem_rd_req, vctr_fifo_wr, seq_busy, seq_done});
        end
        n_cmp++;
        if (mem_rd_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_rd_addr); end
        n_cmp++;
        if (vctr_fifo_din !== 32'h0) begin n_bad++; $display("FAIL reset_din: got %h want 0", vctr_fifo_din); end
        n_cmp++;
        if (outstanding !== 6'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        reqlog.delete(); wlog.delete();
        fixed_en = 1'b1; fixed_data = 32'h1122_3344;
        afifo.push_back(32'h0000_0100);
        run_prog(1, "single");
        n_cmp++;
        if (reqlog.size() != 1 || at(reqlog, 0) !== 32'h100) begin
            n_bad++; $display("FAIL single_req: got %h (n=%0d) want 00000100", at(reqlog, 0), reqlog.size());
        end
        n_cmp++;
        if (at(wlog, 0) !== 32'h1122_3344) begin n_bad++; $display("FAIL single_data: got %h want 11223344", at(wlog, 0)); end
        n_cmp++;
        if (wr_cyc !== val_cyc + 1) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", wr_cyc, val_cyc + 1); end
        fixed_en = 1'b0;
    endtask

    task automatic test_burst;
        logic [31:0] exp_a [8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                   32'h2000, 32'h2004, 32'h2008, 32'h200C};
        reqlog.delete(); wlog.delete();
        send_consec_addr = 1'b1; consec_count = 8'd3;
        afifo.push_back(32'h0000_1000);
        afifo.push_back(32'h0000_2002);
        run_prog(8, "burst");
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (at(reqlog, i) !== exp_a[i]) begin n_bad++; $display("FAIL burst_addr%0d: got %h want %h", i, at(reqlog, i), exp_a[i]); end
            n_cmp++;
            if (at(wlog, i) !== data_of(exp_a[i])) begin n_bad++; $display("FAIL burst_data%0d: got %h want %h", i, at(wlog, i), data_of(exp_a[i])); end
        end
        send_consec_addr = 1'b0; consec_count = 8'd0;
    endtask

    task automatic test_credit;
        int highs;
        reqlog.delete(); wlog.delete();
        ret_en = 1'b0; words_in_vctr_fifo = 16'd8175; highs = 0;
        afifo.push_back(32'h0000_3000);
        afifo.push_back(32'h0000_3010);
        active_program = 1'b1;
        for (int i = 0; i < 100 && reqlog.size() < 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd_req) highs++;
        end
        n_cmp++;
        if (highs != 0 || reqlog.size() != 1) begin
            n_bad++; $display("FAIL credit_hold: got req_high=%0d n=%0d want 0 and 1", highs, reqlog.size());
        end
        n_cmp++;
        if (outstanding !== 6'd1) begin n_bad++; $display("FAIL credit_outstanding: got %0d want 1", outstanding); end
        words_in_vctr_fifo = 16'd8174;
        for (int i = 0; i < 20 && reqlog.size() < 2; i++) @(negedge clk);
        n_cmp++;
        if (at(reqlog, 1) !== 32'h3010) begin n_bad++; $display("FAIL credit_release: got %h want 00003010", at(reqlog, 1)); end
        ret_en = 1'b1; words_in_vctr_fifo = 16'd0;
        run_prog(2, "credit");
    endtask

    task automatic test_freeze;
        reqlog.delete(); wlog.delete();
        freeze_addr_fifo = 1'b1;
        afifo.push_back(32'h0000_6000);
        active_program = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (reqlog.size() != 0 || afifo.size() != 1 || seq_busy !== 1'b1) begin
            n_bad++; $display("FAIL freeze_hold: got reqs=%0d fifo=%0d busy=%b want 0 1 1", reqlog.size(), afifo.size(), seq_busy);
        end
        freeze_addr_fifo = 1'b0;
        run_prog(1, "freeze");
        n_cmp++;
        if (at(reqlog, 0) !== 32'h6000) begin n_bad++; $display("FAIL freeze_req: got %h want 00006000", at(reqlog, 0)); end
    endtask

    task automatic test_wrap_swap;
        reqlog.delete(); wlog.delete();
        vector_byte_swap = 1'b1; fixed_en = 1'b1; fixed_data = 32'hAABB_CCDD;
        send_consec_addr = 1'b1; consec_count = 8'd1;
        afifo.push_back(32'hFFFF_FFFF);
        run_prog(2, "wrap");
        n_cmp++;
        if (at(reqlog, 0) !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got %h want fffffffc", at(reqlog, 0)); end
        n_cmp++;
        if (at(reqlog, 1) !== 32'h0) begin n_bad++; $display("FAIL wrap_next: got %h want 00000000", at(reqlog, 1)); end
        n_cmp++;
        if (at(wlog, 0) !== 32'hDDCC_BBAA) begin n_bad++; $display("FAIL swap_data: got %h want ddccbbaa", at(wlog, 0)); end
        vector_byte_swap = 1'b0; fixed_en = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
    endtask

    task automatic test_abort;
        int d0;
        reqlog.delete(); wlog.delete();
        d0 = done_cnt;
        ret_en = 1'b0; send_consec_addr = 1'b1; consec_count = 8'd9;
        afifo.push_back(32'h0000_4000);
        active_program = 1'b1;
        for (int i = 0; i < 200 && outstanding != 6'd5; i++) @(negedge clk);
        ack_en = 1'b0; abort_program = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_rd_req !== 1'b0) begin n_bad++; $display("FAIL abort_req_drop: got %b want 0", mem_rd_req); end
        n_cmp++;
        if (outstanding !== 6'd5) begin n_bad++; $display("FAIL abort_outstanding: got %0d want 5", outstanding); end
        ack_en = 1'b1; ret_en = 1'b1;
        for (int i = 0; i < 200 && seq_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (seq_busy !== 1'b0 || outstanding !== 6'd0) begin
            n_bad++; $display("FAIL abort_idle: got busy=%b out=%0d want 0 0", seq_busy, outstanding);
        end
        n_cmp++;
        if (wlog.size() != 0) begin n_bad++; $display("FAIL abort_writes: got %0d want 0", wlog.size()); end
        n_cmp++;
        if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_cnt - d0); end
        n_cmp++;
        if (reqlog.size() != 5) begin n_bad++; $display("FAIL abort_reqs: got %0d want 5", reqlog.size()); end
        abort_program = 1'b0; active_program = 1'b0;
        send_consec_addr = 1'b0; consec_count = 8'd0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        wlog.delete();
        ret_en = 1'b0; send_consec_addr = 1'b1; consec_count = 8'd7;
        afifo.push_back(32'h0000_5000);
        active_program = 1'b1;
        for (int i = 0; i < 100 && outstanding < 6'd3; i++) @(negedge clk);
        reset = 1'b0; active_program = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outstanding !== 6'd0 || mem_rd_req !== 1'b0 || seq_busy !== 1'b0) begin
            n_bad++; $display("FAIL midreset_state: got out=%0d req=%b busy=%b want 0 0 0", outstanding, mem_rd_req, seq_busy);
        end
        reset = 1'b1; ret_en = 1'b1; spur = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wlog.size() != 0 || outstanding !== 6'd0) begin
            n_bad++; $display("FAIL midreset_returns: got writes=%0d out=%0d want 0 0", wlog.size(), outstanding);
        end
        send_consec_addr = 1'b0; consec_count = 8'd0; afifo.delete();
        repeat (2) @(negedge clk);
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats;
        reqlog.delete(); wlog.delete();
        send_consec_addr = 1'b1; consec_count = 8'd99;
        afifo.push_back(32'h0001_0000);
        afifo.push_back(32'h0002_0000);
        afifo.push_back(32'h0003_0000);
        run_prog(300, "stats");
        n_cmp++;
        if (total_vctr_fifo_words_written !== 32'd300) begin
            n_bad++; $display("FAIL stats_total: got %0d want 300", total_vctr_fifo_words_written);
        end
        send_consec_addr = 1'b0; consec_count = 8'd0;
    endtask
`endif

    initial begin
        reset = 1'b0; active_program = 1'b0; end_program = 1'b0; abort_program = 1'b0;
        freeze_addr_fifo = 1'b0; freeze_vector_fifo = 1'b0; send_consec_addr = 1'b0;
        consec_count = 8'd0; vector_byte_swap = 1'b0; words_in_vctr_fifo = 16'd0;
        test_reset();
        test_single();
        test_burst();
        test_credit();
        test_freeze();
        test_wrap_swap();
        test_abort();
        test_reset_mid();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
